// File: rtl/rv_multicycle_ctrl_if.sv
// Bus bundle between the multicycle RV32 R-type controller (master) and its
// instruction memory / register file / ALU (slave).
interface rv_multicycle_ctrl_if;
    logic [31:0] INST;
    logic        IRDY;
    logic [31:0] ADDR;
    logic        IREQ;
    logic [4:0]  RR1;
    logic [4:0]  RR2;
    logic [4:0]  WR;
    logic        WE;
    logic [3:0]  ALU_SEL;
    logic [31:0] INSTRET;
    logic [2:0]  STATE;
    logic        ILLEGAL;

    modport master (
        input  INST, IRDY,
        output ADDR, IREQ, RR1, RR2, WR, WE, ALU_SEL, INSTRET, STATE, ILLEGAL
    );

    modport slave (
        output INST, IRDY,
        input  ADDR, IREQ, RR1, RR2, WR, WE, ALU_SEL, INSTRET, STATE, ILLEGAL
    );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXECUTE/WRITEBACK controller for RV32 R-type ops.
// Optional macro ILLEGAL_HALT_EN: an illegal instruction parks the FSM in HALT.
module rv_multicycle_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input logic               CLK,
    input logic               RST,
    rv_multicycle_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        WRITEBACK = 3'd3,
        HALT      = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] instret;
    logic        ireq;
    logic        we;
    logic        illegal;

    logic        legal;
    logic [3:0]  alu_sel;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    always_comb begin
        legal = 1'b0;
        if (opcode == 7'b0110011) begin
            if (funct7 == 7'b0000000)
                legal = 1'b1;
            else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
                legal = 1'b1;
        end
    end

    // Decode fields are pure functions of IR, so they hold from DECODE until the next fetch.
    always_comb begin
        alu_sel = 4'd0;
        case (funct3)
            3'b000:  alu_sel = funct7[5] ? 4'd1 : 4'd0;
            3'b001:  alu_sel = 4'd2;
            3'b010:  alu_sel = 4'd3;
            3'b011:  alu_sel = 4'd4;
            3'b100:  alu_sel = 4'd5;
            3'b101:  alu_sel = funct7[5] ? 4'd7 : 4'd6;
            3'b110:  alu_sel = 4'd8;
            default: alu_sel = 4'd9;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            instret <= '0;
            illegal <= 1'b0;
            ireq    <= 1'b1;
            we      <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.IRDY) begin
                        ir    <= bus.INST;
                        ireq  <= 1'b0;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (legal) begin
                        state <= EXECUTE;
                    end else begin
                        illegal <= 1'b1;
`ifdef ILLEGAL_HALT_EN
                        state   <= HALT;
`else
                        pc      <= pc + PC_STEP;
                        ireq    <= 1'b1;
                        state   <= FETCH;
`endif
                    end
                end
                EXECUTE: begin
                    we    <= (ir[11:7] != 5'd0);
                    state <= WRITEBACK;
                end
                WRITEBACK: begin
                    we      <= 1'b0;
                    pc      <= pc + PC_STEP;
                    instret <= instret + 32'd1;
                    ireq    <= 1'b1;
                    state   <= FETCH;
                end
                HALT: begin
                    ireq  <= 1'b0;
                    we    <= 1'b0;
                    state <= HALT;
                end
                default: begin
                    ireq  <= 1'b1;
                    we    <= 1'b0;
                    state <= FETCH;
                end
            endcase
        end
    end

    assign bus.ADDR    = pc;
    assign bus.IREQ    = ireq;
    assign bus.RR1     = ir[19:15];
    assign bus.RR2     = ir[24:20];
    assign bus.WR      = ir[11:7];
    assign bus.WE      = we;
    assign bus.ALU_SEL = alu_sel;
    assign bus.INSTRET = instret;
    assign bus.STATE   = state;
    assign bus.ILLEGAL = illegal;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Randomized self-checking bench for rv_multicycle_ctrl against a per-instruction
// reference model; a second instance checks PC wrap with RESET_PC at the top of memory.
module tb_rv_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    rv_multicycle_ctrl_if bus ();
    rv_multicycle_ctrl_if bus2 ();

    rv_multicycle_ctrl #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .CLK(clk), .RST(rst), .bus(bus)
    );

    rv_multicycle_ctrl #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut_wrap (
        .CLK(clk), .RST(rst2), .bus(bus2)
    );

    int total = 0;
    int bad = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instret;
    logic        m_ill;

    function automatic logic ref_legal(input logic [31:0] inst);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = inst[31:25];
        f3 = inst[14:12];
        return (inst[6:0] == 7'h33) &&
               ((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
    endfunction

    // Operation number: base op per funct3, alternate (sub/sra) is the next number.
    function automatic logic [3:0] ref_alu(input logic [31:0] inst);
        int base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int v;
        v = base[inst[14:12]] + ((inst[31:25] == 7'h20) ? 1 : 0);
        return 4'(v);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_pc      = 32'h0000_0000;
        m_instret = 32'd0;
        m_ill     = 1'b0;
    endtask

    // Runs one instruction through the DUT with `waits` stall cycles, checking every cycle.
    task automatic run_inst(input logic [31:0] inst, input int waits, input string name);
        logic [36:0] fa, fe;
        logic [18:0] da, de;
        logic [23:0] xa, xe;
        logic [69:0] aa, ae;
        logic        lg;
        lg = ref_legal(inst);
        for (int w = 0; w <= waits; w++) begin
            bus.IRDY = (w == waits);
            bus.INST = (w == waits) ? inst : $urandom;
            fa = {bus.STATE, bus.IREQ, bus.WE, bus.ADDR};
            fe = {3'd0, 1'b1, 1'b0, m_pc};
            total++;
            if (fa !== fe) begin
                bad++;
                $display("FAIL %s fetch[%0d] state/ireq/we/addr got=%h want=%h", name, w, fa, fe);
            end
            step;
        end
        bus.IRDY = 1'($urandom);
        bus.INST = $urandom;
        da = {bus.STATE, bus.WE, bus.RR1, bus.RR2, bus.WR};
        de = {3'd1, 1'b0, inst[19:15], inst[24:20], inst[11:7]};
        total++;
        if (da !== de) begin
            bad++;
            $display("FAIL %s decode state/we/rr1/rr2/wr got=%h want=%h", name, da, de);
        end
        step;
        if (lg) begin
            bus.IRDY = 1'($urandom);
            xa = {bus.STATE, bus.WE, bus.ALU_SEL, bus.RR1, bus.RR2, bus.WR};
            xe = {3'd2, 1'b0, ref_alu(inst), inst[19:15], inst[24:20], inst[11:7]};
            total++;
            if (xa !== xe) begin
                bad++;
                $display("FAIL %s execute state/we/alu/regs got=%h want=%h", name, xa, xe);
            end
            step;
            xa = {bus.STATE, bus.WE, bus.ALU_SEL, bus.RR1, bus.RR2, bus.WR};
            xe = {3'd3, (inst[11:7] != 5'd0), ref_alu(inst), inst[19:15], inst[24:20], inst[11:7]};
            total++;
            if (xa !== xe) begin
                bad++;
                $display("FAIL %s writeback state/we/alu/regs got=%h want=%h", name, xa, xe);
            end
            step;
            m_pc      = m_pc + 32'd4;
            m_instret = m_instret + 32'd1;
        end else begin
            m_ill = 1'b1;
`ifdef ILLEGAL_HALT_EN
            for (int h = 0; h < 3; h++) begin
                bus.IRDY = 1'b1;
                xa = {16'd0, bus.STATE, bus.IREQ, bus.WE, bus.ILLEGAL, 2'd0};
                xe = {16'd0, 3'd4, 1'b0, 1'b0, 1'b1, 2'd0};
                total++;
                if (xa !== xe) begin
                    bad++;
                    $display("FAIL %s halt[%0d] state/ireq/we/illegal got=%h want=%h", name, h, xa, xe);
                end
                step;
            end
            bus.IRDY = 1'b0;
            return;
`else
            m_pc = m_pc + 32'd4;
`endif
        end
        bus.IRDY = 1'b0;
        aa = {bus.STATE, bus.IREQ, bus.WE, bus.ILLEGAL, bus.ADDR, bus.INSTRET};
        ae = {3'd0, 1'b1, 1'b0, m_ill, m_pc, m_instret};
        total++;
        if (aa !== ae) begin
            bad++;
            $display("FAIL %s retire state/ireq/we/ill/addr/instret got=%h want=%h", name, aa, ae);
        end
    endtask

    task automatic test_reset;
        logic [63:0] ra, re;
        rst = 1'b1;
        bus.IRDY = 1'b1;
        bus.INST = 32'h002081B3;
        step;
        step;
        model_reset();
        ra = {bus.STATE, bus.IREQ, bus.WE, bus.ADDR, bus.INSTRET[0], bus.ILLEGAL,
              bus.RR1, bus.RR2, bus.WR, bus.ALU_SEL, 5'd0};
        re = {3'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 5'd0};
        total++;
        if (ra !== re || bus.INSTRET !== 32'd0) begin
            bad++;
            $display("FAIL reset outputs got=%h instret=%h want=%h instret=0", ra, bus.INSTRET, re);
        end
        rst = 1'b0;
        bus.IRDY = 1'b0;
        step;
        total++;
        if ({bus.STATE, bus.IREQ, bus.WE, bus.ADDR} !== {3'd0, 1'b1, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL post_reset state=%0d ireq=%b we=%b addr=%h want 0/1/0/0",
                     bus.STATE, bus.IREQ, bus.WE, bus.ADDR);
        end
    endtask

    task automatic test_add;
        run_inst(32'h002081B3, 0, "add_x3");
        total++;
        if (bus.ADDR !== 32'd4 || bus.INSTRET !== 32'd1) begin
            bad++;
            $display("FAIL add_x3 addr=%h instret=%h want 4/1", bus.ADDR, bus.INSTRET);
        end
    endtask

    task automatic test_wait_sub;
        run_inst(32'h40208133, 3, "sub_wait");
    endtask

    task automatic test_rd0;
        run_inst(32'h00208033, 0, "add_x0");
    endtask

    task automatic test_random;
        logic [31:0] inst;
        int sel;
        for (int n = 0; n < 40; n++) begin
            inst = $urandom;
            sel  = $urandom_range(0, 9);
            inst[31:25] = (sel < 6) ? 7'h00 : (sel < 9) ? 7'h20 : inst[31:25];
            if ($urandom_range(0, 7) != 0)
                inst[6:0] = 7'h33;
            if ($urandom_range(0, 5) == 0)
                inst[11:7] = 5'd0;
`ifdef ILLEGAL_HALT_EN
            if (!ref_legal(inst)) begin
                inst[6:0]   = 7'h33;
                inst[31:25] = 7'h00;
            end
`endif
            run_inst(inst, $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_illegal;
        run_inst(32'h40209033, 0, "illegal");
        total++;
        if (bus.ILLEGAL !== 1'b1) begin
            bad++;
            $display("FAIL illegal_flag got=%b want=1", bus.ILLEGAL);
        end
`ifndef ILLEGAL_HALT_EN
        run_inst(32'h003100B3, 1, "sticky");
`endif
    endtask

    task automatic test_reset_execute;
        rst = 1'b1;
        step;
        rst = 1'b0;
        model_reset();
        run_inst(32'h002081B3, 0, "pre_rst");
        bus.IRDY = 1'b1;
        bus.INST = 32'h40208133;
        step;
        bus.IRDY = 1'b0;
        step;
        total++;
        if (bus.STATE !== 3'd2) begin
            bad++;
            $display("FAIL rst_exec_setup state=%0d want=2", bus.STATE);
        end
        rst = 1'b1;
        step;
        rst = 1'b0;
        model_reset();
        total++;
        if ({bus.STATE, bus.WE, bus.ADDR, bus.INSTRET} !== {3'd0, 1'b0, m_pc, m_instret}) begin
            bad++;
            $display("FAIL rst_exec state=%0d we=%b addr=%h instret=%h want 0/0/%h/%h",
                     bus.STATE, bus.WE, bus.ADDR, bus.INSTRET, m_pc, m_instret);
        end
        step;
        total++;
        if (bus.WE !== 1'b0 || bus.STATE !== 3'd0) begin
            bad++;
            $display("FAIL rst_exec_nowrite we=%b state=%0d want 0/0", bus.WE, bus.STATE);
        end
        run_inst(32'h00A484B3, 0, "after_rst");
    endtask

    task automatic test_pc_wrap;
        bus2.INST = 32'h002081B3;
        bus2.IRDY = 1'b0;
        rst2 = 1'b1;
        step;
        rst2 = 1'b0;
        total++;
        if (bus2.ADDR !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL wrap_reset addr=%h want=fffffffc", bus2.ADDR);
        end
        bus2.IRDY = 1'b1;
        step;
        bus2.IRDY = 1'b0;
        step;
        step;
        total++;
        if (bus2.WE !== 1'b1) begin
            bad++;
            $display("FAIL wrap_we got=%b want=1", bus2.WE);
        end
        step;
        total++;
        if ({bus2.STATE, bus2.ADDR, bus2.INSTRET} !== {3'd0, 32'h0, 32'd1}) begin
            bad++;
            $display("FAIL wrap_pc state=%0d addr=%h instret=%h want 0/0/1",
                     bus2.STATE, bus2.ADDR, bus2.INSTRET);
        end
    endtask

    initial begin
        bus.IRDY  = 1'b0;
        bus.INST  = '0;
        bus2.IRDY = 1'b0;
        bus2.INST = '0;
        model_reset();
        test_reset();
        test_add();
        test_wait_sub();
        test_rd0();
        test_random();
        test_illegal();
        test_reset_execute();
        test_pc_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_multicycle_ctrl.md
RV_MULTICYCLE_CTRL -- requirements
Module: rv_multicycle_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: PC_STEP, 4, PC increment per instruction.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 INST  input  32  instruction word from instruction memory.
REQ-006 IRDY  input  1  instruction memory ready; INST is valid this cycle.
REQ-007 ADDR  output  32  instruction fetch address (current PC).
REQ-008 IREQ  output  1  fetch request.
REQ-009 RR1  output  5  register-file read register 1 (IR[19:15]).
REQ-010 RR2  output  5  register-file read register 2 (IR[24:20]).
REQ-011 WR  output  5  register-file write register (IR[11:7]).
REQ-012 WE  output  1  register-file write enable.
REQ-013 ALU_SEL  output  4  operation: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and.
REQ-014 INSTRET  output  32  retired-instruction counter.
REQ-015 STATE  output  3  current FSM state: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 WRITEBACK, 4 HALT.
REQ-016 ILLEGAL  output  1  sticky flag: illegal instruction decoded.

Function
REQ-017 FETCH: IREQ=1 and ADDR=PC; on IRDY=1, IR<=INST, go to DECODE; on IRDY=0, stay in FETCH with ADDR held.
REQ-018 IRDY is ignored in every state other than FETCH.
REQ-019 DECODE: RR1/RR2/WR driven from IR; legality checked; legal -> EXECUTE.
REQ-020 Legal: opcode 7'b0110011; funct7 0000000 for any funct3, or funct7 0100000 with funct3 000 (sub) or 101 (sra); all other encodings are illegal.
REQ-021 EXECUTE: ALU_SEL valid from funct3/funct7 per REQ-013; lasts one cycle; -> WRITEBACK.
REQ-022 WRITEBACK: WE=1 for exactly one cycle, unless rd==0 (WE stays 0); PC<=PC+PC_STEP; INSTRET<=INSTRET+1; -> FETCH.
REQ-023 WE is 0 in every state other than WRITEBACK.
REQ-024 Latency per legal instruction: fetch wait cycles + 4 (FETCH cycle with IRDY, DECODE, EXECUTE, WRITEBACK).
REQ-025 RR1/RR2/WR/ALU_SEL hold their values from DECODE through WRITEBACK.
REQ-026 PC wraps modulo 2^32 (32'hFFFF_FFFC + 4 -> 0).
REQ-027 INSTRET wraps modulo 2^32.
REQ-028 ILLEGAL, once set, stays set until reset.

Reset
REQ-029 RST=1 at a rising edge, in any state (including mid-fetch and HALT), sets: state FETCH, PC=RESET_PC, IR=0, INSTRET=0, ILLEGAL=0, RR1=RR2=WR=0, ALU_SEL=0.
REQ-030 During and after reset, before the first decode, outputs are: WE=0, IREQ=1, ADDR=RESET_PC.
REQ-031 RST takes priority over IRDY and every state transition.

Configuration
REQ-032 Macro ILLEGAL_HALT_EN: when defined, an illegal instruction in DECODE sets ILLEGAL and moves to HALT; HALT is terminal until reset, with IREQ=0 and WE=0.
REQ-033 Without ILLEGAL_HALT_EN, an illegal instruction sets ILLEGAL, performs no write, does not increment INSTRET, sets PC<=PC+PC_STEP, and goes to FETCH; HALT is unreachable.

Verification
REQ-034 Reset, then INST=32'h002081B3 (add x3,x1,x2) with IRDY=1 -> RR1=1, RR2=2, WR=3, ALU_SEL=0, WE=1 in the 4th cycle, INSTRET=1, ADDR=4.
REQ-035 INST=32'h40208133 (sub x2,x1,x2), IRDY low for 3 cycles then high -> ADDR held at PC during the wait, ALU_SEL=1, WE pulses once 3 cycles after IRDY.
REQ-036 INST=32'h00208033 (add x0,x1,x2) -> WE=0 in WRITEBACK, INSTRET still increments, PC+=4.
REQ-037 INST=32'h40209033 (funct7 0100000, funct3 001) -> ILLEGAL=1; with macro: STATE=4, IREQ=0; without macro: INSTRET unchanged, PC+=4, back to FETCH.
REQ-038 RST asserted in EXECUTE -> next edge: STATE=0, ADDR=RESET_PC, INSTRET=0, WE=0, no write issued.
REQ-039 RESET_PC=32'hFFFF_FFFC, one legal instruction retired -> ADDR=32'h0000_0000.
